// File: rtl/sap_pkg.sv
// Shared constants for the SAP-1 microsequencer: opcodes, control-word bit
// positions and T-state encodings.
package sap_pkg;

    localparam int CTRL_W = 12;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_NOP = 4'h3;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam int CW_HLT       = 11;
    localparam int CW_PC_INC    = 10;
    localparam int CW_PC_EN     = 9;
    localparam int CW_MAR_LOAD  = 8;
    localparam int CW_MEM_EN    = 7;
    localparam int CW_IR_LOAD   = 6;
    localparam int CW_IR_EN     = 5;
    localparam int CW_A_LOAD    = 4;
    localparam int CW_A_EN      = 3;
    localparam int CW_B_LOAD    = 2;
    localparam int CW_ADDER_SUB = 1;
    localparam int CW_ADDER_EN  = 0;

    typedef enum logic [2:0] {
        T0     = 3'd0,
        T1     = 3'd1,
        T2     = 3'd2,
        T3     = 3'd3,
        T4     = 3'd4,
        T_HALT = 3'd7
    } t_state_e;

    function automatic logic [CTRL_W-1:0] cw_bit(input int idx);
        return CTRL_W'(1) << idx;
    endfunction

    // Bits that change register contents; these are suppressed on held cycles
    // so a step that is displayed for several clocks loads only once.
    localparam logic [CTRL_W-1:0] CW_LOAD_MASK =
        (CTRL_W'(1) << CW_PC_INC) | (CTRL_W'(1) << CW_MAR_LOAD) |
        (CTRL_W'(1) << CW_IR_LOAD) | (CTRL_W'(1) << CW_A_LOAD) |
        (CTRL_W'(1) << CW_B_LOAD);

endpackage

// File: rtl/sap_decode_rom.sv
// Combinational micro-op ROM: (T-state, opcode) -> control word plus
// sequencing hints (instruction done, enter HALT, illegal condition seen).
module sap_decode_rom
    import sap_pkg::*;
(
    input  t_state_e          t_state,
    input  logic [3:0]        opcode,
    output logic [CTRL_W-1:0] ctrl,
    output logic              done,
    output logic              to_halt,
    output logic              illegal_hit
);

    always_comb begin
        ctrl        = '0;
        done        = 1'b0;
        to_halt     = 1'b0;
        illegal_hit = 1'b0;
        case (t_state)
            T0: ctrl = cw_bit(CW_PC_EN) | cw_bit(CW_MAR_LOAD);
            T1: ctrl = cw_bit(CW_MEM_EN) | cw_bit(CW_IR_LOAD) | cw_bit(CW_PC_INC);
            T2: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB:
                        ctrl = cw_bit(CW_IR_EN) | cw_bit(CW_MAR_LOAD);
                    OP_NOP: done = 1'b1;
                    OP_HLT: begin
                        ctrl    = cw_bit(CW_HLT);
                        to_halt = 1'b1;
                    end
                    default: begin
                        done        = 1'b1;
                        illegal_hit = 1'b1;
                    end
                endcase
            end
            T3: begin
                case (opcode)
                    OP_LDA: begin
                        ctrl = cw_bit(CW_MEM_EN) | cw_bit(CW_A_LOAD);
                        done = 1'b1;
                    end
                    OP_ADD, OP_SUB:
                        ctrl = cw_bit(CW_MEM_EN) | cw_bit(CW_B_LOAD);
                    // IR is stable in practice; an unexpected change just ends the instruction.
                    default: done = 1'b1;
                endcase
            end
            T4: begin
                done = 1'b1;
                case (opcode)
                    OP_ADD: ctrl = cw_bit(CW_ADDER_EN) | cw_bit(CW_A_LOAD);
                    OP_SUB: ctrl = cw_bit(CW_ADDER_EN) | cw_bit(CW_ADDER_SUB) |
                                   cw_bit(CW_A_LOAD);
                    default: ctrl = '0;
                endcase
            end
            T_HALT: ctrl = cw_bit(CW_HLT);
            default: illegal_hit = 1'b1;
        endcase
    end

endmodule

// File: rtl/sap_microsequencer.sv
// SAP-1 T-state sequencer: state register, step gating, sticky halt/illegal
// flags and retired counter. Optional single-step build: SAP_SINGLE_STEP_EN.
module sap_microsequencer
    import sap_pkg::*;
#(
    parameter int OPC_W = 4,
    parameter int CW_W  = 12,
    parameter int RET_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [OPC_W-1:0] opcode,
`ifdef SAP_SINGLE_STEP_EN
    input  logic             step_mode,
    input  logic             step,
`endif
    output logic [CW_W-1:0]  ctrl_out,
    output logic [2:0]       t_state,
    output logic             halted,
    output logic             illegal,
    output logic [RET_W-1:0] retired
);

    t_state_e          state;
    t_state_e          next_state;
    logic [CTRL_W-1:0] rom_ctrl;
    logic [CTRL_W-1:0] gated_ctrl;
    logic              rom_done;
    logic              rom_to_halt;
    logic              rom_illegal;
    logic              advance;

    sap_decode_rom u_decode (
        .t_state     (state),
        .opcode      (opcode[3:0]),
        .ctrl        (rom_ctrl),
        .done        (rom_done),
        .to_halt     (rom_to_halt),
        .illegal_hit (rom_illegal)
    );

`ifdef SAP_SINGLE_STEP_EN
    assign advance = !step_mode || step;
`else
    assign advance = 1'b1;
`endif

    always_comb begin
        next_state = T0;
        if (rom_to_halt)
            next_state = T_HALT;
        else if (rom_done)
            next_state = T0;
        else begin
            case (state)
                T0:      next_state = T1;
                T1:      next_state = T2;
                T2:      next_state = T3;
                T3:      next_state = T4;
                T_HALT:  next_state = T_HALT;
                default: next_state = T0;
            endcase
        end
    end

    always_comb begin
        gated_ctrl = advance ? rom_ctrl : (rom_ctrl & ~CW_LOAD_MASK);
        ctrl_out   = rst ? '0 : CW_W'(gated_ctrl);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= T0;
            illegal <= 1'b0;
            retired <= '0;
        end else if (advance) begin
            state <= next_state;
            if (rom_illegal)
                illegal <= 1'b1;
            if (rom_done)
                retired <= retired + RET_W'(1);
        end
    end

    assign t_state = state;
    assign halted  = (state == T_HALT);

endmodule

// File: tb/tb_sap_microsequencer.sv
// Directed bench for sap_microsequencer with a small SAP-1 datapath model
// (PC, MAR, RAM, IR, A, B, adder) driven by the sequencer's control word.
module tb_sap_microsequencer;
    import sap_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  opcode;
    logic [11:0] ctrl_out;
    logic [2:0]  t_state;
    logic        halted;
    logic        illegal;
    logic [7:0]  retired;
`ifdef SAP_SINGLE_STEP_EN
    logic        step_mode = 1'b0;
    logic        step = 1'b0;
`endif

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [7:0] ram [16];
    logic [3:0] pc  = 4'h0;
    logic [3:0] mar = 4'h0;
    logic [7:0] ir  = 8'h00;
    logic [7:0] a   = 8'h00;
    logic [7:0] b   = 8'h00;
    logic [7:0] bus;

    always #5 clk = ~clk;

    sap_microsequencer dut (
        .clk       (clk),
        .rst       (rst),
        .opcode    (opcode),
`ifdef SAP_SINGLE_STEP_EN
        .step_mode (step_mode),
        .step      (step),
`endif
        .ctrl_out  (ctrl_out),
        .t_state   (t_state),
        .halted    (halted),
        .illegal   (illegal),
        .retired   (retired)
    );

    assign opcode = ir[7:4];

    always_comb begin
        bus = 8'h00;
        if (ctrl_out[CW_PC_EN])        bus = {4'h0, pc};
        else if (ctrl_out[CW_MEM_EN])  bus = ram[mar];
        else if (ctrl_out[CW_IR_EN])   bus = {4'h0, ir[3:0]};
        else if (ctrl_out[CW_A_EN])    bus = a;
        else if (ctrl_out[CW_ADDER_EN]) bus = ctrl_out[CW_ADDER_SUB] ? a - b : a + b;
    end

    // Clear resets PC/MAR/IR only; A and B keep their contents.
    always @(posedge clk) begin
        if (rst) begin
            pc  <= 4'h0;
            mar <= 4'h0;
            ir  <= 8'h00;
        end else begin
            if (ctrl_out[CW_PC_INC])   pc  <= pc + 4'h1;
            if (ctrl_out[CW_MAR_LOAD]) mar <= bus[3:0];
            if (ctrl_out[CW_IR_LOAD])  ir  <= bus;
            if (ctrl_out[CW_A_LOAD])   a   <= bus;
            if (ctrl_out[CW_B_LOAD])   b   <= bus;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run time exceeded, got no finish, required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_ram;
        for (int i = 0; i < 16; i++) ram[i] = 8'h00;
    endtask

    task automatic apply_reset;
        rst = 1'b1;
        #1;
        if (ctrl_out !== 12'h000) begin
            $display("FAIL rst_ctrl: got %03h, required 000", ctrl_out);
            err_cnt++;
        end
        vec_cnt++;
        tick(1);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        clear_ram();
        ram[0] = 8'h30;
        @(negedge clk);
        apply_reset();
        if (t_state !== 3'd0 || halted !== 1'b0 || illegal !== 1'b0 || retired !== 8'h00) begin
            $display("FAIL reset_state: got t=%0d h=%b i=%b r=%0d, required t=0 h=0 i=0 r=0",
                     t_state, halted, illegal, retired);
            err_cnt++;
        end
        vec_cnt++;
    endtask

    task automatic test_lda;
        logic [11:0] exp_cw [4];
        logic [2:0]  exp_t  [4];
        exp_cw = '{12'h300, 12'h4C0, 12'h120, 12'h090};
        exp_t  = '{3'd0, 3'd1, 3'd2, 3'd3};
        clear_ram();
        ram[0]  = 8'h0E;
        ram[14] = 8'h2A;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            if (ctrl_out !== exp_cw[i] || t_state !== exp_t[i]) begin
                $display("FAIL lda_step%0d: got ctrl=%03h t=%0d, required ctrl=%03h t=%0d",
                         i, ctrl_out, t_state, exp_cw[i], exp_t[i]);
                err_cnt++;
            end
            vec_cnt++;
            tick(1);
        end
        if (t_state !== 3'd0 || retired !== 8'd1 || a !== 8'h2A) begin
            $display("FAIL lda_done: got t=%0d r=%0d a=%02h, required t=0 r=1 a=2a",
                     t_state, retired, a);
            err_cnt++;
        end
        vec_cnt++;
    endtask

    task automatic test_add_sub;
        clear_ram();
        ram[0]  = 8'h0E;
        ram[1]  = 8'h1F;
        ram[2]  = 8'h2F;
        ram[3]  = 8'hF0;
        ram[14] = 8'h05;
        ram[15] = 8'h03;
        apply_reset();
        tick(4);
        if (a !== 8'd5) begin
            $display("FAIL addsub_lda: got a=%0d, required 5", a);
            err_cnt++;
        end
        vec_cnt++;
        tick(4);
        if (t_state !== 3'd4 || ctrl_out !== 12'h011) begin
            $display("FAIL add_t4: got t=%0d ctrl=%03h, required t=4 ctrl=011", t_state, ctrl_out);
            err_cnt++;
        end
        vec_cnt++;
        tick(1);
        if (a !== 8'd8 || b !== 8'd3 || retired !== 8'd2 || t_state !== 3'd0) begin
            $display("FAIL add_done: got a=%0d b=%0d r=%0d t=%0d, required a=8 b=3 r=2 t=0",
                     a, b, retired, t_state);
            err_cnt++;
        end
        vec_cnt++;
        tick(4);
        if (t_state !== 3'd4 || ctrl_out !== 12'h013) begin
            $display("FAIL sub_t4: got t=%0d ctrl=%03h, required t=4 ctrl=013", t_state, ctrl_out);
            err_cnt++;
        end
        vec_cnt++;
        tick(1);
        if (a !== 8'd5 || retired !== 8'd3) begin
            $display("FAIL sub_done: got a=%0d r=%0d, required a=5 r=3", a, retired);
            err_cnt++;
        end
        vec_cnt++;
    endtask

    task automatic test_halt;
        tick(2);
        if (t_state !== 3'd2 || ctrl_out !== 12'h800 || halted !== 1'b0) begin
            $display("FAIL hlt_t2: got t=%0d ctrl=%03h h=%b, required t=2 ctrl=800 h=0",
                     t_state, ctrl_out, halted);
            err_cnt++;
        end
        vec_cnt++;
        tick(1);
        for (int i = 0; i < 20; i++) begin
            if (halted !== 1'b1 || t_state !== 3'd7 || ctrl_out !== 12'h800 || retired !== 8'd3) begin
                $display("FAIL halt_hold%0d: got h=%b t=%0d ctrl=%03h r=%0d, required h=1 t=7 ctrl=800 r=3",
                         i, halted, t_state, ctrl_out, retired);
                err_cnt++;
            end
            vec_cnt++;
            tick(1);
        end
    endtask

    task automatic test_illegal;
        clear_ram();
        ram[0]  = 8'h70;
        ram[1]  = 8'h0E;
        ram[14] = 8'h11;
        apply_reset();
        if (halted !== 1'b0) begin
            $display("FAIL halt_cleared: got h=%b, required 0", halted);
            err_cnt++;
        end
        vec_cnt++;
        tick(2);
        if (t_state !== 3'd2 || ctrl_out !== 12'h000 || illegal !== 1'b0) begin
            $display("FAIL ill_t2: got t=%0d ctrl=%03h i=%b, required t=2 ctrl=000 i=0",
                     t_state, ctrl_out, illegal);
            err_cnt++;
        end
        vec_cnt++;
        tick(1);
        if (t_state !== 3'd0 || illegal !== 1'b1 || retired !== 8'd1) begin
            $display("FAIL ill_set: got t=%0d i=%b r=%0d, required t=0 i=1 r=1",
                     t_state, illegal, retired);
            err_cnt++;
        end
        vec_cnt++;
        tick(4);
        if (illegal !== 1'b1 || a !== 8'h11 || retired !== 8'd2) begin
            $display("FAIL ill_sticky: got i=%b a=%02h r=%0d, required i=1 a=11 r=2",
                     illegal, a, retired);
            err_cnt++;
        end
        vec_cnt++;
        apply_reset();
        if (illegal !== 1'b0 || retired !== 8'd0) begin
            $display("FAIL ill_clear: got i=%b r=%0d, required i=0 r=0", illegal, retired);
            err_cnt++;
        end
        vec_cnt++;
    endtask

    task automatic test_reset_mid;
        clear_ram();
        ram[0]  = 8'h0E;
        ram[1]  = 8'h1F;
        ram[14] = 8'h05;
        ram[15] = 8'h09;
        apply_reset();
        tick(7);
        if (t_state !== 3'd3 || a !== 8'd5 || b !== 8'd3 || retired !== 8'd1) begin
            $display("FAIL mid_pre: got t=%0d a=%0d b=%0d r=%0d, required t=3 a=5 b=3 r=1",
                     t_state, a, b, retired);
            err_cnt++;
        end
        vec_cnt++;
        rst = 1'b1;
        #1;
        if (ctrl_out !== 12'h000) begin
            $display("FAIL mid_rst_ctrl: got %03h, required 000", ctrl_out);
            err_cnt++;
        end
        vec_cnt++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        if (t_state !== 3'd0 || a !== 8'd5 || b !== 8'd3 || retired !== 8'd0) begin
            $display("FAIL mid_post: got t=%0d a=%0d b=%0d r=%0d, required t=0 a=5 b=3 r=0",
                     t_state, a, b, retired);
            err_cnt++;
        end
        vec_cnt++;
    endtask

`ifdef SAP_SINGLE_STEP_EN
    task automatic test_single_step;
        int inc_cnt;
        int moves;
        logic [2:0] prev_t;
        clear_ram();
        ram[0]  = 8'h0E;
        ram[14] = 8'h3C;
        apply_reset();
        step_mode = 1'b1;
        inc_cnt = 0;
        moves = 0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            step = (cyc % 4 == 3);
            #1;
            if (ctrl_out[CW_PC_INC]) inc_cnt++;
            prev_t = t_state;
            tick(1);
            if (t_state != prev_t) moves++;
            if (!step && t_state !== prev_t) begin
                $display("FAIL step_hold%0d: got t=%0d, required t=%0d", cyc, t_state, prev_t);
                err_cnt++;
            end
            vec_cnt++;
        end
        step = 1'b0;
        if (inc_cnt !== 1 || moves !== 4 || t_state !== 3'd0 || retired !== 8'd1 || a !== 8'h3C) begin
            $display("FAIL step_run: got inc=%0d moves=%0d t=%0d r=%0d a=%02h, required inc=1 moves=4 t=0 r=1 a=3c",
                     inc_cnt, moves, t_state, retired, a);
            err_cnt++;
        end
        vec_cnt++;
        step_mode = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_lda();
        test_add_sub();
        test_halt();
        test_illegal();
        test_reset_mid();
`ifdef SAP_SINGLE_STEP_EN
        test_single_step();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
